// File: rtl/fir_interp_ctrl_pkg.sv
// fir_interp_ctrl_pkg
//   Shared definitions for the polyphase FIR interpolator sequencer:
//   - sequencer state encodings (ST_IDLE / ST_LOAD / ST_RUN)
//   - helpers that derive the stored-coefficient count (NC), the taps per
//     phase (T) and a safe counter width from the filter parameters.
package fir_interp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Half-symmetric storage: only (ORD+1)/2 coefficients are kept.
  function automatic int num_coeffs(input int ord);
    return (ord + 1) / 2;
  endfunction

  // Taps evaluated per polyphase phase.
  function automatic int taps_per_phase(input int ord, input int m);
    return (ord + 1) / m;
  endfunction

  // Width of a counter over 0..modulus-1; never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/fir_interp_ctrl_mod_cnt.sv
// mod_cnt
//   Modulo-MOD up counter with enable, synchronous clear and a wrap flag.
//   The wrap back to zero is an explicit compare against MOD-1, so MOD need
//   not be a power of two.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   en    in   advance the count by one
//   clr   in   synchronous clear to 0 (takes priority over en)
//   cnt   out  current count, 0..MOD-1
//   wrap  out  high in the cycle the count advances from MOD-1 to 0
module mod_cnt #(
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count and wrap flag.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fir_interp_ctrl.sv
// fir_interp_ctrl
//   Sequencer for the polyphase FIR interpolator. On start it streams the
//   half-symmetric coefficient set from a synchronous ROM into the filter's
//   coefficient port, then runs the fixed sample schedule: one input strobe
//   per M output periods, one D-clock output period per phase, a T-cycle MAC
//   window and an output strobe in every period.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle request: (re)load coefficients, then run
//   rom_addr / rom_data   ROM read port (data valid one cycle after address)
//   c_we / c_addr / c_in  coefficient write port of the filter
//   loaded                coefficients complete, schedule running
//   in_stb                filter captures a new input sample
//   phase                 current polyphase phase
//   mac_en / tap_idx      MAC window and tap within the phase
//   out_stb               filter output for `phase` is final
// All outputs are decoded from registered state; c_in passes rom_data
// through only while the registered write stage is active.
module fir_interp_ctrl
  import fir_interp_ctrl_pkg::*;
#(
  parameter  int ORD        = 255,
  parameter  int M          = 8,
  parameter  int D          = 100,
  parameter  int COEFF_SIZE = 16,
  localparam int NC         = num_coeffs(ORD),
  localparam int T          = taps_per_phase(ORD, M),
  localparam int AW         = $clog2(NC),
  localparam int PW         = $clog2(M),
  localparam int TW         = $clog2(T)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [AW-1:0]         rom_addr,
  input  logic [COEFF_SIZE-1:0] rom_data,
  output logic                  c_we,
  output logic [AW-1:0]         c_addr,
  output logic [COEFF_SIZE-1:0] c_in,
  output logic                  loaded,
  output logic                  in_stb,
  output logic [PW-1:0]         phase,
  output logic                  mac_en,
  output logic [TW-1:0]         tap_idx,
  output logic                  out_stb
);

  localparam int SW = cnt_width(D);
  localparam int LW = AW + 1;  // load counter must reach NC itself

  localparam logic [LW-1:0] NC_L   = LW'(NC);
  localparam logic [LW-1:0] ONE_L  = LW'(1);
  localparam logic [AW-1:0] LAST_A = AW'(NC - 1);
  localparam logic [SW-1:0] ONE_S  = SW'(1);
  localparam logic [SW-1:0] T_S    = SW'(T);
  localparam logic [SW-1:0] T1_S   = SW'(T + 1);

  if (((ORD + 1) % (2 * M)) != 0) begin : g_chk_div
    $error("fir_interp_ctrl: ORD+1 must be divisible by 2*M");
  end
  if (D < T + 2) begin : g_chk_d
    $error("fir_interp_ctrl: D must be at least T+2");
  end

  state_e          state_q, state_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic            in_stb_q, in_stb_d;

  logic            run_s;
  logic [SW-1:0]   slot_s;
  logic            slot_wrap_s;
  logic [PW-1:0]   phase_s;
  logic            phase_wrap_s;

  assign run_s = (state_q == ST_RUN);

  // Counters are held at zero outside RUN, so RUN always starts at slot 0, phase 0.
  mod_cnt #(.MOD(D), .W(SW)) u_slot_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (run_s),
    .clr  (~run_s),
    .cnt  (slot_s),
    .wrap (slot_wrap_s)
  );

  mod_cnt #(.MOD(M), .W(PW)) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (slot_wrap_s),
    .clr  (~run_s),
    .cnt  (phase_s),
    .wrap (phase_wrap_s)
  );

  // Next-state logic: read stage (lcnt) runs one cycle ahead of the write stage (wr).
  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    in_stb_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          lcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (lcnt_q < NC_L) begin
          wr_d      = 1'b1;
          wr_addr_d = lcnt_q[AW-1:0];
          lcnt_d    = lcnt_q + ONE_L;
        end else begin
          wr_d = 1'b0;
        end
        if (wr_q && (wr_addr_q == LAST_A)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_LOAD;
          lcnt_d  = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        lcnt_d  = '0;
      end
    endcase
    // Input strobe marks the first slot of phase 0: on RUN entry and after the last slot of phase M-1.
    if ((state_d == ST_RUN) && ((state_q == ST_LOAD) || phase_wrap_s)) begin
      in_stb_d = 1'b1;
    end else begin
      in_stb_d = 1'b0;
    end
  end

  // State and load-pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lcnt_q    <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      in_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      in_stb_q  <= in_stb_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    rom_addr = '0;
    c_we     = 1'b0;
    c_addr   = '0;
    c_in     = '0;
    loaded   = 1'b0;
    in_stb   = 1'b0;
    phase    = '0;
    mac_en   = 1'b0;
    tap_idx  = '0;
    out_stb  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (lcnt_q < NC_L) begin
          rom_addr = lcnt_q[AW-1:0];
        end else begin
          rom_addr = '0;
        end
        if (wr_q) begin
          c_we   = 1'b1;
          c_addr = wr_addr_q;
          c_in   = rom_data;
        end else begin
          c_we = 1'b0;
        end
      end
      ST_RUN: begin
        loaded  = 1'b1;
        in_stb  = in_stb_q;
        phase   = phase_s;
        out_stb = (slot_s == T1_S);
        if ((slot_s >= ONE_S) && (slot_s <= T_S)) begin
          mac_en  = 1'b1;
          tap_idx = TW'(slot_s - ONE_S);
        end else begin
          mac_en  = 1'b0;
          tap_idx = '0;
        end
      end
      default: begin
        loaded = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_interp_ctrl.sv
// Directed self-checking bench for fir_interp_ctrl: default configuration
// (ORD=255, M=8, D=100) plus a small one (ORD=7, M=2, D=6). Each DUT has a
// synchronous ROM model returning address*3.
module tb_fir_interp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT
  logic        rst0, start0;
  logic [6:0]  rom_addr0, c_addr0;
  logic [15:0] rom_data0, c_in0;
  logic        c_we0, loaded0, in_stb0, mac_en0, out_stb0;
  logic [2:0]  phase0;
  logic [4:0]  tap_idx0;

  // Small DUT: ORD=7, M=2, D=6 -> NC=4, T=4
  logic        rst1, start1;
  logic [1:0]  rom_addr1, c_addr1;
  logic [15:0] rom_data1, c_in1;
  logic        c_we1, loaded1, in_stb1, mac_en1, out_stb1;
  logic [0:0]  phase1;
  logic [1:0]  tap_idx1;

  fir_interp_ctrl u_dut0 (
    .clk(clk), .rst(rst0), .start(start0),
    .rom_addr(rom_addr0), .rom_data(rom_data0),
    .c_we(c_we0), .c_addr(c_addr0), .c_in(c_in0),
    .loaded(loaded0), .in_stb(in_stb0), .phase(phase0),
    .mac_en(mac_en0), .tap_idx(tap_idx0), .out_stb(out_stb0)
  );

  fir_interp_ctrl #(.ORD(7), .M(2), .D(6), .COEFF_SIZE(16)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .c_we(c_we1), .c_addr(c_addr1), .c_in(c_in1),
    .loaded(loaded1), .in_stb(in_stb1), .phase(phase1),
    .mac_en(mac_en1), .tap_idx(tap_idx1), .out_stb(out_stb1)
  );

  // Synchronous ROM models: data = address * 3.
  always @(posedge clk) begin
    rom_data0 <= {9'd0, rom_addr0} * 16'd3;
    rom_data1 <= {14'd0, rom_addr1} * 16'd3;
  end

  typedef struct packed {
    logic [31:0] rom_addr, c_we, c_addr, c_in, loaded, in_stb, phase, mac_en, tap_idx, out_stb;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.rom_addr = 32'(rom_addr0); o.c_we   = 32'(c_we0);   o.c_addr  = 32'(c_addr0);
      o.c_in     = 32'(c_in0);     o.loaded = 32'(loaded0); o.in_stb  = 32'(in_stb0);
      o.phase    = 32'(phase0);    o.mac_en = 32'(mac_en0); o.tap_idx = 32'(tap_idx0);
      o.out_stb  = 32'(out_stb0);
    end else begin
      o.rom_addr = 32'(rom_addr1); o.c_we   = 32'(c_we1);   o.c_addr  = 32'(c_addr1);
      o.c_in     = 32'(c_in1);     o.loaded = 32'(loaded1); o.in_stb  = 32'(in_stb1);
      o.phase    = 32'(phase1);    o.mac_en = 32'(mac_en1); o.tap_idx = 32'(tap_idx1);
      o.out_stb  = 32'(out_stb1);
    end
    return o;
  endfunction

  task automatic chk_all_zero(input string pfx, input int sel);
    obs_t o;
    o = get_obs(sel);
    chk({pfx, "_rom_addr"}, o.rom_addr, 0);
    chk({pfx, "_c_we"},     o.c_we,     0);
    chk({pfx, "_c_addr"},   o.c_addr,   0);
    chk({pfx, "_c_in"},     o.c_in,     0);
    chk({pfx, "_loaded"},   o.loaded,   0);
    chk({pfx, "_in_stb"},   o.in_stb,   0);
    chk({pfx, "_phase"},    o.phase,    0);
    chk({pfx, "_mac_en"},   o.mac_en,   0);
    chk({pfx, "_tap_idx"},  o.tap_idx,  0);
    chk({pfx, "_out_stb"},  o.out_stb,  0);
  endtask

  // Pulse start from IDLE/RUN and check the full load sequence (cycles 1..NC+2).
  // Extra start pulses are raised at cycles p1/p2 and must be ignored.
  task automatic do_load(input int sel, input int nc, input int p1, input int p2);
    obs_t o;
    int writes;
    writes = 0;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    for (int c = 1; c <= nc + 1; c++) begin
      o = get_obs(sel);
      chk("ld_rom_addr", o.rom_addr, (c - 1 < nc) ? c - 1 : 0);
      if (c == 1) begin
        chk("ld_first_c_we", o.c_we, 0);
        chk("ld_first_c_addr", o.c_addr, 0);
      end else begin
        chk("ld_c_we", o.c_we, 1);
        chk("ld_c_addr", o.c_addr, c - 2);
        chk("ld_c_in", o.c_in, 3 * (c - 2));
      end
      chk("ld_loaded", o.loaded, 0);
      chk("ld_in_stb", o.in_stb, 0);
      chk("ld_out_stb", o.out_stb, 0);
      chk("ld_mac_en", o.mac_en, 0);
      chk("ld_phase", o.phase, 0);
      writes += int'(o.c_we);
      if (c == p1 || c == p2) set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
    end
    o = get_obs(sel);
    chk("ld_n_writes", writes, nc);
    chk("run_entry_loaded", o.loaded, 1);
    chk("run_entry_in_stb", o.in_stb, 1);
    chk("run_entry_phase", o.phase, 0);
    chk("run_entry_c_we", o.c_we, 0);
    chk("run_entry_rom_addr", o.rom_addr, 0);
  endtask

  // Check ncyc RUN cycles starting at RUN cycle index r0 (0 = RUN entry).
  task automatic run_check(input int sel, input int ncyc, input int r0,
                           input int d, input int m, input int t);
    obs_t o;
    int slot, ph, last_in, last_out;
    last_in  = -1;
    last_out = -1;
    for (int r = r0; r < r0 + ncyc; r++) begin
      o    = get_obs(sel);
      slot = r % d;
      ph   = (r / d) % m;
      chk("run_loaded",  o.loaded,  1);
      chk("run_in_stb",  o.in_stb,  (slot == 0 && ph == 0) ? 1 : 0);
      chk("run_phase",   o.phase,   ph);
      chk("run_mac_en",  o.mac_en,  (slot >= 1 && slot <= t) ? 1 : 0);
      chk("run_tap_idx", o.tap_idx, (slot >= 1 && slot <= t) ? slot - 1 : 0);
      chk("run_out_stb", o.out_stb, (slot == t + 1) ? 1 : 0);
      chk("run_c_we",    o.c_we,    0);
      chk("run_rom_addr", o.rom_addr, 0);
      chk("run_c_in",    o.c_in,    0);
      if (o.in_stb != 0) begin
        if (last_in >= 0) chk("in_stb_gap", r - last_in, m * d);
        last_in = r;
      end
      if (o.out_stb != 0) begin
        if (last_out >= 0) chk("out_stb_gap", r - last_out, d);
        last_out = r;
      end
      tick();
    end
  endtask

  initial begin
    obs_t o;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset", 0);
    rst0 = 1'b0;
    tick(); tick();
    chk_all_zero("idle", 0);

    // Full load, then 2140 RUN cycles ending at phase 5 slot 40
    do_load(0, 128, -1, -1);
    run_check(0, 2140, 0, 100, 8, 32);
    o = get_obs(0);
    chk("pre_restart_phase", o.phase, 5);
    chk("pre_restart_mac_en", o.mac_en, 0);

    // Restart from RUN: load from address 0 again, RUN resumes at phase 0
    do_load(0, 128, -1, -1);
    run_check(0, 200, 0, 100, 8, 32);

    // Reset mid-LOAD at c_addr=60
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    repeat (61) tick();
    o = get_obs(0);
    chk("mid_load_c_addr", o.c_addr, 60);
    chk("mid_load_c_we", o.c_we, 1);
    #1 rst0 = 1'b1;
    #1;
    chk_all_zero("async_rst", 0);
    tick();
    rst0 = 1'b0;
    tick(); tick();
    chk_all_zero("post_rst_idle", 0);

    // start together with rst: reset wins, DUT stays IDLE
    rst0 = 1'b1; start0 = 1'b1;
    tick();
    rst0 = 1'b0; start0 = 1'b0;
    tick(); tick();
    chk_all_zero("rst_wins", 0);

    // Reload after reset
    do_load(0, 128, -1, -1);
    run_check(0, 100, 0, 100, 8, 32);

    // start pulses during LOAD are ignored
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    tick();
    do_load(0, 128, 10, 127);
    run_check(0, 900, 0, 100, 8, 32);

    // Small configuration
    rst1 = 1'b0;
    tick();
    chk_all_zero("small_idle", 1);
    do_load(1, 4, -1, -1);
    run_check(1, 40, 0, 6, 2, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
